nn_layer: RTL and testbench

NN_LAYER -- requirements
Module: nn_layer

---
 rtl/nn_pkg.sv | 34 +++
 rtl/nn_sat_acc.sv | 40 ++++
 rtl/nn_layer.sv | 187 ++++++++++++++++++
 tb/tb_nn_layer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the binary-input neural layer: FSM state encoding,
// activation-mode constants and the saturating adder used by the accumulator.
// No ports; imported by nn_sat_acc and nn_layer.
package nn_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_EMIT  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam int ACT_STEP = 0;
  localparam int ACT_RELU = 1;

  // Adds two values that are already sign-extended to 64 bits and clamps the
  // result to the signed range of a w-bit number (w <= 62, so the 64-bit sum
  // itself can never overflow).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int                 w);
    logic signed [63:0] s;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    s  = a + b;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    if (s > mx)      sat_add = mx;
    else if (s < mn) sat_add = mn;
    else             sat_add = s;
  endfunction

endpackage

// File: rtl/nn_sat_acc.sv
// Clearable, enable-gated signed accumulator that saturates instead of wrapping.
// Ports: clk/reset (sync, active-high), clr (zero the sum), en (add din),
// din (signed weight), acc_nxt (value the accumulator takes on the next edge).
module nn_sat_acc
  import nn_pkg::*;
#(
  parameter int W_WIDTH   = 16,
  parameter int ACC_WIDTH = 24
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [W_WIDTH-1:0]   din,
  output logic signed [ACC_WIDTH-1:0] acc_nxt
);

  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      // Both operands are signed, so the 64-bit casts sign-extend.
      acc_d = ACC_WIDTH'(sat_add(64'(acc_q), 64'(din), ACC_WIDTH));
    end
  end

  // Exposing the next value lets the layer register the activated result on
  // the same edge that absorbs the bias word.
  assign acc_nxt = acc_d;

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/nn_layer.sv
// Fully connected layer with binary inputs: for each neuron, sums the weights of
// set input bits plus a bias read from an external ROM, then applies step/ReLU.
// Ports: clk, reset (sync, active-high), start, in_bits -> busy, w_addr/w_data
// ROM port (1-cycle read latency), out_valid/out_idx/out_act per neuron, done.
module nn_layer
  import nn_pkg::*;
#(
  parameter int N_IN      = 784,
  parameter int N_OUT     = 10,   // must be >= 2 so out_idx has at least one bit
  parameter int W_WIDTH   = 16,
  parameter int ACC_WIDTH = 24,   // >= W_WIDTH and <= 62
  parameter int ACT_MODE  = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [N_IN-1:0]                       in_bits,
  output logic                                  busy,
  output logic [$clog2(N_OUT*(N_IN+1))-1:0]     w_addr,
  input  logic signed [W_WIDTH-1:0]             w_data,
  output logic                                  out_valid,
  output logic [$clog2(N_OUT)-1:0]              out_idx,
  output logic [ACC_WIDTH-1:0]                  out_act,
  output logic                                  done
);

  localparam int AW = $clog2(N_OUT*(N_IN+1));
  localparam int IW = $clog2(N_OUT);
  localparam int CW = $clog2(N_IN+1);

  localparam logic [CW-1:0] I_LAST = CW'(N_IN);
  localparam logic [IW-1:0] N_LAST = IW'(N_OUT - 1);

  state_t                state_q,   state_d;
  logic [IW-1:0]         n_q,       n_d;
  logic [CW-1:0]         i_q,       i_d;
  logic [N_IN-1:0]       in_lat_q,  in_lat_d;
  logic [AW-1:0]         ptr_q,     ptr_d;      // next ROM address to issue
  logic [AW-1:0]         w_addr_q,  w_addr_d;
  logic                  dv_q,      dv_d;       // w_data this cycle belongs to us
  logic                  take_q,    take_d;     // ... and should be accumulated
  logic                  busy_q,    busy_d;
  logic                  out_valid_q, out_valid_d;
  logic [IW-1:0]         out_idx_q, out_idx_d;
  logic [ACC_WIDTH-1:0]  out_act_q, out_act_d;
  logic                  done_q,    done_d;

  logic                  acc_clr;
  logic                  acc_en;
  logic                  bit_sel;
  logic signed [ACC_WIDTH-1:0] acc_nxt;

  function automatic logic [ACC_WIDTH-1:0] activate(input logic [ACC_WIDTH-1:0] a);
    if (ACT_MODE == ACT_STEP) begin
      return (!a[ACC_WIDTH-1] && (a != '0)) ? ACC_WIDTH'(1) : '0;
    end else begin
      return a[ACC_WIDTH-1] ? '0 : a;
    end
  endfunction

  // Latched input bit for the word currently being addressed; the bias slot
  // (i == N_IN) shifts the mask off the end and reads as 0.
  assign bit_sel = |(in_lat_q & (N_IN'(1) << i_q));

  // ROM data lags the address by one cycle, so the add is gated by flags that
  // were registered alongside the address.
  assign acc_en  = dv_q && take_q;
  assign acc_clr = (state_q == S_EMIT) || ((state_q == S_IDLE) && start);

  nn_sat_acc #(
    .W_WIDTH   (W_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_acc (
    .clk     (clk),
    .reset   (reset),
    .clr     (acc_clr),
    .en      (acc_en),
    .din     (w_data),
    .acc_nxt (acc_nxt)
  );

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    i_d         = i_q;
    in_lat_d    = in_lat_q;
    ptr_d       = ptr_q;
    w_addr_d    = '0;
    dv_d        = (state_q == S_FETCH);
    take_d      = (i_q == I_LAST) || bit_sel;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    out_idx_d   = out_idx_q;
    out_act_d   = out_act_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FETCH;
          in_lat_d = in_bits;
          n_d      = '0;
          i_d      = '0;
          w_addr_d = '0;
          ptr_d    = AW'(1);
          busy_d   = 1'b1;
        end
      end
      S_FETCH: begin
        if (i_q == I_LAST) begin
          state_d = S_DRAIN;
          i_d     = '0;
        end else begin
          i_d      = i_q + CW'(1);
          w_addr_d = ptr_q;
          ptr_d    = ptr_q + AW'(1);
        end
      end
      S_DRAIN: begin
        // acc_nxt already includes the bias word arriving this cycle.
        state_d     = S_EMIT;
        out_valid_d = 1'b1;
        out_idx_d   = n_q;
        out_act_d   = activate(acc_nxt);
      end
      S_EMIT: begin
        if (n_q == N_LAST) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          state_d  = S_FETCH;
          n_d      = n_q + IW'(1);
          w_addr_d = ptr_q;
          ptr_d    = ptr_q + AW'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      i_q         <= '0;
      in_lat_q    <= '0;
      ptr_q       <= '0;
      w_addr_q    <= '0;
      dv_q        <= 1'b0;
      take_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_act_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      i_q         <= i_d;
      in_lat_q    <= in_lat_d;
      ptr_q       <= ptr_d;
      w_addr_q    <= w_addr_d;
      dv_q        <= dv_d;
      take_q      <= take_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_act_q   <= out_act_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign w_addr    = w_addr_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_act   = out_act_q;
  assign done      = done_q;

endmodule

// File: tb/tb_nn_layer.sv
// Testbench for nn_layer: three instances (step, ReLU, 8-bit saturating) of a
// 4-input / 2-neuron layer, each fed by a small ROM model with 1-cycle latency.
module tb_nn_layer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start0, start1, start2;
  logic [3:0] bits0, bits1, bits2;

  logic        busy0, busy1, busy2;
  logic [3:0]  waddr0, waddr1, waddr2;
  logic signed [15:0] wdata0, wdata1;
  logic signed [7:0]  wdata2;
  logic        vld0, vld1, vld2;
  logic [0:0]  idx0, idx1, idx2;
  logic [23:0] act0, act1;
  logic [7:0]  act2;
  logic        done0, done1, done2;

  logic signed [15:0] rom [0:9];

  nn_layer #(.N_IN(4), .N_OUT(2), .W_WIDTH(16), .ACC_WIDTH(24), .ACT_MODE(0)) u_step (
    .clk(clk), .reset(reset), .start(start0), .in_bits(bits0), .busy(busy0),
    .w_addr(waddr0), .w_data(wdata0), .out_valid(vld0), .out_idx(idx0),
    .out_act(act0), .done(done0));

  nn_layer #(.N_IN(4), .N_OUT(2), .W_WIDTH(16), .ACC_WIDTH(24), .ACT_MODE(1)) u_relu (
    .clk(clk), .reset(reset), .start(start1), .in_bits(bits1), .busy(busy1),
    .w_addr(waddr1), .w_data(wdata1), .out_valid(vld1), .out_idx(idx1),
    .out_act(act1), .done(done1));

  nn_layer #(.N_IN(4), .N_OUT(2), .W_WIDTH(8), .ACC_WIDTH(8), .ACT_MODE(1)) u_sat (
    .clk(clk), .reset(reset), .start(start2), .in_bits(bits2), .busy(busy2),
    .w_addr(waddr2), .w_data(wdata2), .out_valid(vld2), .out_idx(idx2),
    .out_act(act2), .done(done2));

  always @(posedge clk) begin
    wdata0 <= (waddr0 < 4'd10) ? rom[waddr0] : 16'sd0;
    wdata1 <= (waddr1 < 4'd10) ? rom[waddr1] : 16'sd0;
    wdata2 <= 8'sd127;
  end

  // Monitor mux: the instance under test is chosen by sel.
  int          sel;
  logic        m_busy, m_vld, m_done;
  logic [3:0]  m_waddr;
  logic [0:0]  m_idx;
  logic [23:0] m_act;

  always_comb begin
    m_busy = busy0; m_vld = vld0; m_done = done0; m_waddr = waddr0; m_idx = idx0; m_act = act0;
    if (sel == 1) begin
      m_busy = busy1; m_vld = vld1; m_done = done1; m_waddr = waddr1; m_idx = idx1; m_act = act1;
    end else if (sel == 2) begin
      m_busy = busy2; m_vld = vld2; m_done = done2; m_waddr = waddr2; m_idx = idx2; m_act = {16'd0, act2};
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 0) start0 = v; else if (s == 1) start1 = v; else start2 = v;
  endtask

  task automatic set_bits(input int s, input logic [3:0] b);
    if (s == 0) bits0 = b; else if (s == 1) bits1 = b; else bits2 = b;
  endtask

  function automatic logic [3:0] exp_waddr(input int c);
    if (c >= 1 && c <= 5)  return 4'(c - 1);
    if (c >= 8 && c <= 12) return 4'(c - 3);
    return 4'd0;
  endfunction

  // One full evaluation. Cycle c is the c-th cycle after the accepting edge.
  task automatic run_eval(input int s, input logic [3:0] b, input bit scramble,
                          input bit hold, input logic [23:0] e0, input logic [23:0] e1);
    int nv = 0, nd = 0, dcyc = 0, werr = 0;
    int vc[4];
    logic [0:0]  vi[4];
    logic [23:0] va[4];
    for (int k = 0; k < 4; k++) begin vc[k] = 0; vi[k] = '0; va[k] = '0; end
    sel = s;
    @(negedge clk);
    set_bits(s, b);
    set_start(s, 1'b1);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!hold) set_start(s, 1'b0);
      if (scramble && c == 1) set_bits(s, ~b);
      if (c == 1) chk("busy_after_accept", {31'd0, m_busy}, 32'd1);
      if (c <= 15 && m_waddr !== exp_waddr(c)) werr++;
      if (m_vld) begin
        if (nv < 4) begin vc[nv] = c; vi[nv] = m_idx; va[nv] = m_act; end
        nv++;
      end
      if (m_done) begin nd++; dcyc = c; end
      if (dcyc != 0 && c == dcyc + 1) begin
        chk("busy_low_after_fin", {31'd0, m_busy}, 32'd0);
        break;
      end
    end
    chk("valid_count", nv, 2);
    chk("done_count", nd, 1);
    chk("done_cycle", dcyc, 15);
    chk("valid0_cycle", vc[0], 7);
    chk("valid1_cycle", vc[1], 14);
    chk("idx0", {31'd0, vi[0]}, 32'd0);
    chk("idx1", {31'd0, vi[1]}, 32'd1);
    chk("act0", {8'd0, va[0]}, {8'd0, e0});
    chk("act1", {8'd0, va[1]}, {8'd0, e1});
    chk("waddr_mismatches", werr, 0);
  endtask

  typedef struct {
    int          s;
    logic [3:0]  b;
    logic [23:0] e0;
    logic [23:0] e1;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int nv, nd;
    rom[0] = 16'sd1;  rom[1] = 16'sd2;  rom[2] = 16'sd3;  rom[3] = 16'sd4;  rom[4] = -16'sd5;
    rom[5] = -16'sd1; rom[6] = -16'sd1; rom[7] = -16'sd1; rom[8] = -16'sd1; rom[9] = 16'sd2;

    tbl[0] = '{0, 4'b0101, 24'd0,   24'd0};
    tbl[1] = '{0, 4'b1111, 24'd1,   24'd0};
    tbl[2] = '{0, 4'b0011, 24'd0,   24'd0};
    tbl[3] = '{0, 4'b1100, 24'd1,   24'd0};
    tbl[4] = '{0, 4'b0000, 24'd0,   24'd1};
    tbl[5] = '{1, 4'b1111, 24'd5,   24'd0};
    tbl[6] = '{1, 4'b1000, 24'd0,   24'd1};
    tbl[7] = '{1, 4'b0000, 24'd0,   24'd2};
    tbl[8] = '{1, 4'b1110, 24'd4,   24'd0};
    tbl[9] = '{2, 4'b1111, 24'd127, 24'd127};

    sel = 0;
    reset = 1'b1;
    start0 = 0; start1 = 0; start2 = 0;
    bits0 = '0; bits1 = '0; bits2 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy",  {31'd0, busy0}, 32'd0);
    chk("rst_valid", {31'd0, vld0},  32'd0);
    chk("rst_done",  {31'd0, done0}, 32'd0);
    chk("rst_idx",   {31'd0, idx0},  32'd0);
    chk("rst_act",   {8'd0, act0},   32'd0);
    chk("rst_waddr", {28'd0, waddr0}, 32'd0);

    for (int t = 0; t < 10; t++)
      run_eval(tbl[t].s, tbl[t].b, 1'b0, 1'b0, tbl[t].e0, tbl[t].e1);

    // Inputs changed right after acceptance: results follow the latched 1111.
    run_eval(1, 4'b1111, 1'b1, 1'b0, 24'd5, 24'd0);

    // start held high throughout, including FIN: one result set, then the
    // start still high in the following IDLE cycle begins a new evaluation.
    run_eval(1, 4'b1111, 1'b0, 1'b1, 24'd5, 24'd0);
    @(negedge clk);
    start1 = 1'b0;
    chk("restart_after_fin_busy", {31'd0, busy1}, 32'd1);
    nv = 0; nd = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (vld1) nv++;
      if (done1) nd++;
    end
    chk("restart_valid_count", nv, 2);
    chk("restart_done_count", nd, 1);

    // Reset during neuron 1 FETCH.
    sel = 0;
    @(negedge clk);
    bits0 = 4'b0101;
    start0 = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    chk("mid_fetch_waddr", {28'd0, waddr0}, 32'd6);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_busy",  {31'd0, busy0},  32'd0);
    chk("reset_waddr", {28'd0, waddr0}, 32'd0);
    chk("reset_valid", {31'd0, vld0},   32'd0);
    nv = 0; nd = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (vld0) nv++;
      if (done0) nd++;
    end
    chk("post_reset_valids", nv, 0);
    chk("post_reset_dones", nd, 0);
    run_eval(0, 4'b0101, 1'b0, 1'b0, 24'd0, 24'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
